ready_skid: RTL and testbench
=============================

Name: ready_skid

Overview:
- Ready-path register slice on the dti interface; the complement of the forward-registered decoupler.
- Data passes combinationally from din to dout with zero latency whenever the buffer is empty.
- din.ready is driven straight from a flop, so no combinational path runs from dout.ready back to din.ready.
- Placed at the consumer end of long ready chains to close timing on the backward handshake path.

Parameters:
DEPTH, 2, skid storage entries; legal range 1..256; any integer (not limited to powers of two).
DIN, 16, data width in bits.

Ports:
clk  input  1  clock; all flops sample on the rising edge.
rst  input  1  asynchronous, active-low reset: low = reset asserted, release is synchronised externally.
din  dti.consumer  DIN  upstream interface (data, valid in; ready out).
dout  dti.producer  DIN  downstream interface (data, valid out; ready in).

Behaviour:
State:
- mem[0..DEPTH-1], each DIN bits.
- w_ptr and r_ptr, each 0..DEPTH-1; each wraps to 0 after DEPTH-1 (explicit compare, not power-of-2 masking).
- cnt, 0..DEPTH.
- rdy_q: the flop that drives din.ready.

Reset (rst low, asynchronous):
- cnt = 0, w_ptr = 0, r_ptr = 0, rdy_q = 0.
- Memory contents are not reset.
- Outputs during reset: din.ready = 0, dout.valid = 0.
- First rising edge after rst goes high sets rdy_q = 1.

Definitions:
- empty = (cnt == 0).
- in_xfer = din.valid & din.ready.
- bypass = empty & in_xfer & dout.ready.
- wr = in_xfer & ~bypass.
- rd = ~empty & dout.ready.
- cnt_nxt = cnt + wr - rd.

Outputs:
- dout.valid = ~empty | in_xfer.
- dout.data = empty ? din.data : mem[r_ptr].
- din.ready = rdy_q.

Update on each rising edge:
- if wr: mem[w_ptr] <= din.data; w_ptr advances.
- if rd: r_ptr advances.
- cnt <= cnt_nxt.
- rdy_q <= (cnt_nxt < DEPTH).

Latency:
- 0 cycles when empty and dout.ready = 1 (bypass).
- Otherwise data is delivered in order from storage, one beat per cycle while dout.ready = 1.

Ordering:
- Strict FIFO.
- Bypass only occurs when empty, so a new beat can never overtake stored beats.

Full:
- cnt == DEPTH forces rdy_q = 0, so no write can occur.
- Because rdy_q is computed from cnt_nxt, din.ready = 1 guarantees at least one free slot this cycle; overflow is impossible.

Simultaneous events:
- rd & wr at cnt == DEPTH-1 keeps cnt unchanged and rdy_q stays 1.
- At cnt == DEPTH, wr cannot occur; a rd re-asserts din.ready on the next cycle (one-cycle bubble is inherent and required).

Stall:
- empty, in_xfer, dout.ready = 0 → the beat is stored.
- Next cycle dout shows the same data with valid held; satisfies dti valid/data stability.

dout.ready:
- Never affects din.ready in the same cycle.

Reset mid-operation:
- All stored beats are discarded and dout.valid drops immediately (asynchronously).
- No partial transfer is reported after reset release.

Test Plan:
1. Reset release, DEPTH=2 → din.ready=0 and dout.valid=0 while rst low; din.ready=1 on the first edge after release.
2. Bypass: dout.ready=1 constantly, din sends 0x0001..0x0010 back-to-back → dout shows each value in the same cycle, 16 beats in 16 cycles, cnt stays 0.
3. Stall fill: dout.ready=0, din sends 0xA, 0xB → both accepted; din.ready=0 from the cycle after 0xB. dout.ready=1 → 0xA then 0xB, din.ready back to 1 one cycle after 0xA leaves.
4. Full with simultaneous read/write, DEPTH=3: fill to 2, then din.valid=1 and dout.ready=1 for 5 cycles → cnt held at 2, din.ready never drops, order preserved.
5. Random valid/ready at 50% each, DEPTH in {1, 3, 4}, 10k beats → output sequence equals input sequence; no beat lost or duplicated; din.ready never depends combinationally on dout.ready (check with a same-cycle toggle).
6. Reset mid-operation: cnt=2, pull rst low between clock edges → dout.valid=0 immediately; after release, fresh beat 0x55 passes through in bypass with no stale data.

Source files
------------

// File: rtl/dti.sv
// Valid/ready streaming handshake: producer drives data and valid, consumer drives ready.
interface dti #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/ready_skid.sv
// Ready-path register slice: data bypasses combinationally while the skid store is empty,
// and din.ready comes straight from a flop so the backward handshake path is cut.
module ready_skid #(
  parameter int DEPTH = 2,
  parameter int DIN   = 16
) (
  input logic  clk,
  input logic  rst,
  dti.consumer din,
  dti.producer dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DIN-1:0] mem_q [DEPTH];
  logic [PW-1:0]  w_ptr_q, w_ptr_d;
  logic [PW-1:0]  r_ptr_q, r_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rdy_q, rdy_d;

  logic empty, in_xfer, bypass, wr, rd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;

    empty   = (cnt_q == '0);
    in_xfer = din.valid & rdy_q;
    bypass  = empty & in_xfer & dout.ready;
    wr      = in_xfer & ~bypass;
    rd      = ~empty & dout.ready;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    if (wr) w_ptr_d = (w_ptr_q == PW'(DEPTH - 1)) ? '0 : w_ptr_q + 1'b1;
    if (rd) r_ptr_d = (r_ptr_q == PW'(DEPTH - 1)) ? '0 : r_ptr_q + 1'b1;

    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    // Looking at next-cycle occupancy guarantees a free slot whenever ready is high.
    rdy_d = (cnt_d < CW'(DEPTH));
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // NOTE: storage is deliberately left unreset; cnt gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr) mem_q[w_ptr_q] <= din.data;
  end

  assign dout.valid = ~empty | in_xfer;
  assign dout.data  = empty ? din.data : mem_q[r_ptr_q];
  assign din.ready  = rdy_q;

endmodule

// File: tb/tb_ready_skid.sv
// Bench for ready_skid: four instances (DEPTH 1..4) checked every cycle against a queue-level model.
module tb_ready_skid;

  localparam int N = 4;
  localparam int W = 16;
  localparam int QS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [N];
  logic [W-1:0] in_data   [N];
  logic         out_ready [N];
  wire          in_ready  [N];
  wire          out_valid [N];
  wire  [W-1:0] out_data  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dti #(.W(W)) din_i ();
    dti #(.W(W)) dout_i ();
    assign din_i.valid  = in_valid[g];
    assign din_i.data   = in_data[g];
    assign dout_i.ready = out_ready[g];
    assign in_ready[g]  = din_i.ready;
    assign out_valid[g] = dout_i.valid;
    assign out_data[g]  = dout_i.data;
    ready_skid #(.DEPTH(g + 1), .DIN(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din_i),
      .dout (dout_i)
    );
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-instance FIFO of accepted-but-undelivered beats plus the expected ready.
  logic [W-1:0] m_buf  [N][QS];
  int           m_head [N];
  int           m_cnt  [N];
  bit           m_rdy  [N];
  int           beats_acc [N];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_head[k] = 0;
      m_cnt[k]  = 0;
      m_rdy[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      bit ix, ox;
      ix = in_valid[k] & m_rdy[k];
      ox = out_ready[k] & ((m_cnt[k] > 0) | ix);
      if (ix) begin
        m_buf[k][(m_head[k] + m_cnt[k]) % QS] = in_data[k];
        m_cnt[k]++;
        beats_acc[k]++;
      end
      if (ox) begin
        m_head[k] = (m_head[k] + 1) % QS;
        m_cnt[k]--;
      end
      m_rdy[k] = (m_cnt[k] < k + 1);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      bit ix, exp_v;
      logic [W-1:0] exp_d;
      ix    = in_valid[k] & m_rdy[k];
      exp_v = (m_cnt[k] > 0) | ix;
      n_assert++;
      if (in_ready[k] !== m_rdy[k]) begin
        n_fail++;
        $display("FAIL %s d%0d din.ready: got %b want %b", tag, k + 1, in_ready[k], m_rdy[k]);
      end
      n_assert++;
      if (out_valid[k] !== exp_v) begin
        n_fail++;
        $display("FAIL %s d%0d dout.valid: got %b want %b", tag, k + 1, out_valid[k], exp_v);
      end
      if (exp_v) begin
        exp_d = (m_cnt[k] > 0) ? m_buf[k][m_head[k]] : in_data[k];
        n_assert++;
        if (out_data[k] !== exp_d) begin
          n_fail++;
          $display("FAIL %s d%0d dout.data: got %h want %h", tag, k + 1, out_data[k], exp_d);
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    #1 check_outputs(tag);
    // din.ready must not react to a same-cycle change of dout.ready.
    for (int k = 0; k < N; k++) out_ready[k] = ~out_ready[k];
    #1;
    for (int k = 0; k < N; k++) begin
      n_assert++;
      if (in_ready[k] !== m_rdy[k]) begin
        n_fail++;
        $display("FAIL %s d%0d ready_comb: got %b want %b", tag, k + 1, in_ready[k], m_rdy[k]);
      end
      out_ready[k] = ~out_ready[k];
    end
    #1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_all(input bit v, input logic [W-1:0] d, input bit r);
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = v;
      in_data[k]   = d;
      out_ready[k] = r;
    end
  endtask

  task automatic drain(input int n);
    drive_all(1'b0, '0, 1'b1);
    for (int i = 0; i < n; i++) cycle("drain");
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_all(1'b1, 16'h1234, 1'b1);
    model_reset();
    #2;
    for (int k = 0; k < N; k++) begin
      n_assert++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset d%0d ready/valid: got %b/%b want 0/0", k + 1, in_ready[k], out_valid[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    drive_all(1'b0, '0, 1'b1);
    cycle("release");
    n_assert++;
    if (in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: got %b want 1", in_ready[1]);
    end
  endtask

  task automatic test_bypass();
    for (int i = 1; i <= 16; i++) begin
      drive_all(1'b1, W'(i), 1'b1);
      #1;
      n_assert++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== W'(i) || in_ready[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL bypass beat %0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, out_valid[1], out_data[1], in_ready[1], W'(i));
      end
      cycle("bypass");
    end
    drain(2);
  endtask

  task automatic test_stall_fill();
    drive_all(1'b1, 16'h000A, 1'b0);
    cycle("fill_a");
    drive_all(1'b1, 16'h000B, 1'b0);
    cycle("fill_b");
    drive_all(1'b0, '0, 1'b0);
    #1;
    n_assert++;
    if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || out_data[1] !== 16'h000A) begin
      n_fail++;
      $display("FAIL stall_full: got r=%b v=%b d=%h want r=0 v=1 d=000a",
               in_ready[1], out_valid[1], out_data[1]);
    end
    cycle("stall");
    drive_all(1'b0, '0, 1'b1);
    cycle("unload_a");
    n_assert++;
    if (in_ready[1] !== 1'b1 || out_data[1] !== 16'h000B) begin
      n_fail++;
      $display("FAIL unload_b: got r=%b d=%h want r=1 d=000b", in_ready[1], out_data[1]);
    end
    drain(3);
  endtask

  task automatic test_full_simul();
    drive_all(1'b1, 16'h0010, 1'b0);
    cycle("pre_a");
    drive_all(1'b1, 16'h0011, 1'b0);
    cycle("pre_b");
    for (int i = 0; i < 5; i++) begin
      drive_all(1'b1, W'(16'h0020 + i), 1'b1);
      #1;
      n_assert++;
      if (in_ready[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL rdwr_hold cycle %0d: got %b want 1", i, in_ready[2]);
      end
      cycle("rdwr");
    end
    drain(6);
  endtask

  task automatic test_random();
    int cyc;
    int start0;
    cyc = 0;
    start0 = beats_acc[0];
    while ((beats_acc[0] - start0) < 10000 && cyc < 60000) begin
      for (int k = 0; k < N; k++) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        in_data[k]   = W'($urandom);
        out_ready[k] = 1'($urandom_range(0, 1));
      end
      cycle("random");
      cyc++;
    end
    n_assert++;
    if (cyc >= 60000) begin
      n_fail++;
      $display("FAIL random_budget: got %0d beats want 10000", beats_acc[0] - start0);
    end
    drain(8);
    for (int k = 0; k < N; k++) begin
      n_assert++;
      if (out_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL random_empty d%0d: got %b want 0", k + 1, out_valid[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_all(1'b1, 16'h0031, 1'b0);
    cycle("mid_a");
    drive_all(1'b1, 16'h0032, 1'b0);
    cycle("mid_b");
    drive_all(1'b0, '0, 1'b0);
    #1 rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) begin
      n_assert++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset d%0d v/r: got %b/%b want 0/0", k + 1, out_valid[k], in_ready[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    cycle("mid_release");
    drive_all(1'b1, 16'h0055, 1'b1);
    #1;
    for (int k = 0; k < N; k++) begin
      n_assert++;
      if (out_valid[k] !== 1'b1 || out_data[k] !== 16'h0055) begin
        n_fail++;
        $display("FAIL fresh_bypass d%0d: got v=%b d=%h want v=1 d=0055", k + 1, out_valid[k], out_data[k]);
      end
    end
    cycle("fresh");
    drain(2);
  endtask

  initial begin
    for (int k = 0; k < N; k++) beats_acc[k] = 0;
    rst = 1'b0;
    drive_all(1'b0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_stall_fill();
    test_full_simul();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
